// File: rtl/addsub_op_sequencer_if.sv
// Signal bundle between the op sequencer, its command/response clients and the registered adder.
// The sequencer connects through the slave modport; the client and adder side connects through master.
interface addsub_op_sequencer_if #(
  parameter int N  = 16,
  parameter int CW = 8
);
  // command channel
  logic          CmdValid;
  logic          CmdReady;
  logic [1:0]    CmdOp;
  logic [N-1:0]  CmdA;
  logic [N-1:0]  CmdB;
  // adder control and result
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic          Sel;
  logic          AddSub;
  logic [N-1:0]  Z;
  logic          Overflow;
  // response channel and status
  logic          RspValid;
  logic          RspReady;
  logic [N-1:0]  RspData;
  logic          RspOvf;
  logic          Busy;
  logic [CW-1:0] OvfCount;

  modport master (
    output CmdValid, CmdOp, CmdA, CmdB, RspReady, Z, Overflow,
    input  CmdReady, A, B, Sel, AddSub, RspValid, RspData, RspOvf, Busy, OvfCount
  );

  modport slave (
    input  CmdValid, CmdOp, CmdA, CmdB, RspReady, Z, Overflow,
    output CmdReady, A, B, Sel, AddSub, RspValid, RspData, RspOvf, Busy, OvfCount
  );
endinterface

// File: rtl/addsub_op_sequencer.sv
// Command front-end for the two-stage registered adder/subtractor: issues one op for a single
// cycle, holds the accumulator with Z+0 otherwise, and returns the captured result on a response port.
module addsub_op_sequencer #(
  parameter int N  = 16,
  parameter int CW = 8
) (
  input logic                 Clock,
  input logic                 Resetn,
  addsub_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, RESP} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  a_q, a_nx;
  logic [N-1:0]  b_q, b_nx;
  logic          sel_q, sel_nx;
  logic          sub_q, sub_nx;
  logic          rsp_valid_q, rsp_valid_nx;
  logic [N-1:0]  data_q, data_nx;
  logic          ovf_q, ovf_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic          ready_q;
  logic          busy_q;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx     = state;
    a_nx         = '0;
    b_nx         = '0;
    sel_nx       = 1'b1;
    sub_nx       = 1'b0;
    rsp_valid_nx = rsp_valid_q;
    data_nx      = data_q;
    ovf_nx       = ovf_q;
    cnt_nx       = cnt_q;

    case (state)
      IDLE: begin
        if (bus.CmdValid) begin
          a_nx     = bus.CmdOp[1] ? '0 : bus.CmdA;
          b_nx     = bus.CmdB;
          sel_nx   = bus.CmdOp[1];
          sub_nx   = bus.CmdOp[0];
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT:  state_nx = CAPT;
      CAPT: begin
        // Overflow only reflects our op on this edge; afterwards it tracks the hold op.
        data_nx      = bus.Z;
        ovf_nx       = bus.Overflow;
        rsp_valid_nx = 1'b1;
        if (bus.Overflow && (cnt_q != '1)) begin
          cnt_nx = cnt_q + CW'(1);
        end
        state_nx = RESP;
      end
      RESP: begin
        if (bus.RspReady) begin
          rsp_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= 1'b1;
      sub_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      a_q         <= a_nx;
      b_q         <= b_nx;
      sel_q       <= sel_nx;
      sub_q       <= sub_nx;
      rsp_valid_q <= rsp_valid_nx;
      data_q      <= data_nx;
      ovf_q       <= ovf_nx;
      cnt_q       <= cnt_nx;
      // Status flags are registered from the next state so they line up with it.
      ready_q     <= (state_nx == IDLE);
      busy_q      <= (state_nx != IDLE);
    end
  end

  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.Sel      = sel_q;
  assign bus.AddSub   = sub_q;
  assign bus.RspValid = rsp_valid_q;
  assign bus.RspData  = data_q;
  assign bus.RspOvf   = ovf_q;
  assign bus.OvfCount = cnt_q;
  assign bus.CmdReady = ready_q;
  assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_addsub_op_sequencer.sv
// Bench for addsub_op_sequencer: a behavioural adder environment, a transaction-level reference
// model, a per-cycle compare process, directed scenarios with literal results and a random phase.
module tb_addsub_op_sequencer;
  localparam int N   = 16;
  localparam int CW  = 8;
  localparam int CW2 = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  addsub_op_sequencer_if #(.N(N), .CW(CW))  bus ();
  addsub_op_sequencer_if #(.N(N), .CW(CW2)) bus2 ();

  addsub_op_sequencer #(.N(N), .CW(CW))  dut  (.Clock(clk), .Resetn(rst_n), .bus(bus.slave));
  addsub_op_sequencer #(.N(N), .CW(CW2)) dut2 (.Clock(clk), .Resetn(rst_n), .bus(bus2.slave));

  // the narrow-counter instance sees exactly the same traffic
  assign bus2.CmdValid = bus.CmdValid;
  assign bus2.CmdOp    = bus.CmdOp;
  assign bus2.CmdA     = bus.CmdA;
  assign bus2.CmdB     = bus.CmdB;
  assign bus2.RspReady = bus.RspReady;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- adder environment (input regs, then Zreg) ----------------
  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sel;
    logic         sub;
  } op_t;

  function automatic logic [N:0] adder_eval(input op_t o, input logic [N-1:0] z);
    logic [N-1:0] x, r;
    logic         ov;
    x  = o.sel ? z : o.a;
    r  = o.sub ? x - o.b : x + o.b;
    ov = o.sub ? ((x[N-1] != o.b[N-1]) && (r[N-1] != x[N-1]))
               : ((x[N-1] == o.b[N-1]) && (r[N-1] != x[N-1]));
    return {ov, r};
  endfunction

  op_t in1, in2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in1 <= '{a: '0, b: '0, sel: 1'b1, sub: 1'b0};
      in2 <= '{a: '0, b: '0, sel: 1'b1, sub: 1'b0};
      {bus.Overflow, bus.Z}   <= '0;
      {bus2.Overflow, bus2.Z} <= '0;
    end else begin
      in1 <= '{a: bus.A, b: bus.B, sel: bus.Sel, sub: bus.AddSub};
      in2 <= '{a: bus2.A, b: bus2.B, sel: bus2.Sel, sub: bus2.AddSub};
      {bus.Overflow, bus.Z}   <= adder_eval(in1, bus.Z);
      {bus2.Overflow, bus2.Z} <= adder_eval(in2, bus2.Z);
    end
  end

  // ---------------- reference model (transaction level) ----------------
  // pend: -1 when no op is in flight, otherwise edges elapsed since the accept edge.
  int           pend   = -1;
  logic [N-1:0] acc    = '0;
  logic [1:0]   p_op   = '0;
  logic [N-1:0] p_a    = '0;
  logic [N-1:0] p_b    = '0;
  logic [N-1:0] p_res  = '0;
  logic         p_ovf  = 1'b0;
  logic [N-1:0] m_data = '0;
  logic         m_ovf  = 1'b0;
  int           m_cnt  = 0;

  always @(posedge clk) begin
    int x, s;
    if (!rst_n) begin
      pend = -1; acc = '0; m_data = '0; m_ovf = 1'b0; m_cnt = 0;
    end else if (pend >= 3) begin
      if (bus.RspReady) pend = -1;
    end else if (pend >= 0) begin
      pend++;
      if (pend == 3) begin
        m_data = p_res;
        m_ovf  = p_ovf;
        m_cnt  = m_cnt + int'(p_ovf);
      end
    end else if (bus.CmdValid) begin
      p_op  = bus.CmdOp;
      p_a   = bus.CmdA;
      p_b   = bus.CmdB;
      x     = p_op[1] ? int'($signed(acc)) : int'($signed(p_a));
      s     = p_op[0] ? x - int'($signed(p_b)) : x + int'($signed(p_b));
      p_ovf = (s > 32767) || (s < -32768);
      p_res = N'(s);
      acc   = p_res;
      pend  = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      check("cmd_ready",  bus.CmdReady, pend < 0);
      check("busy",       bus.Busy,     pend >= 0);
      check("rsp_valid",  bus.RspValid, pend >= 3);
      check("a_out",      bus.A,        (pend == 0 && !p_op[1]) ? p_a : '0);
      check("b_out",      bus.B,        (pend == 0) ? p_b : '0);
      check("sel_out",    bus.Sel,      (pend == 0) ? p_op[1] : 1'b1);
      check("addsub_out", bus.AddSub,   (pend == 0) ? p_op[0] : 1'b0);
      check("ovf_count",  bus.OvfCount, (m_cnt > 255) ? 255 : m_cnt);
      check("ovf_count2", bus2.OvfCount, (m_cnt > 3) ? 3 : m_cnt);
      check("rsp_valid2", bus2.RspValid, pend >= 3);
      if (pend >= 3) begin
        check("rsp_data",  bus.RspData,  m_data);
        check("rsp_ovf",   bus.RspOvf,   m_ovf);
        check("rsp_data2", bus2.RspData, m_data);
      end
    end
  end

  // ---------------- response/accept monitor ----------------
  logic [N:0] rsp_q[$];
  time        dut_acc_t = 0;
  time        dut_hs_t  = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.RspValid && bus.RspReady) begin
        rsp_q.push_back({bus.RspOvf, bus.RspData});
        dut_hs_t = $time;
      end
      if (bus.CmdValid && bus.CmdReady) dut_acc_t = $time;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int w;
    bus.CmdValid = 1'b1;
    bus.CmdOp    = op;
    bus.CmdA     = a;
    bus.CmdB     = b;
    w = 0;
    while (!bus.CmdReady && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("cmd_accept", bus.CmdReady, 1'b1);
    @(negedge clk);
    bus.CmdValid = 1'b0;
  endtask

  task automatic get_rsp(output logic [N-1:0] d, output logic o);
    int w;
    w = 0;
    while (rsp_q.size() == 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("rsp_arrived", rsp_q.size() > 0, 1'b1);
    if (rsp_q.size() > 0) {o, d} = rsp_q.pop_front();
    else {o, d} = 'x;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed and random stimulus ----------------
  logic [N-1:0] d;
  logic         o;
  bit           rnd_on;
  int           exp6[5] = '{1, 2, 3, 3, 3};

  initial begin
    bus.CmdValid = 1'b0;
    bus.CmdOp    = '0;
    bus.CmdA     = '0;
    bus.CmdB     = '0;
    bus.RspReady = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", bus.CmdReady, 1'b1);
    check("rst_busy",      bus.Busy,     1'b0);
    check("rst_sel",       bus.Sel,      1'b1);
    check("rst_a",         bus.A,        '0);
    check("rst_b",         bus.B,        '0);
    check("rst_addsub",    bus.AddSub,   1'b0);
    check("rst_rsp_valid", bus.RspValid, 1'b0);
    check("rst_rsp_data",  bus.RspData,  '0);
    check("rst_ovf_count", bus.OvfCount, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // 5 + 3, then Z - 2, then hold for 10 idle cycles
    send(2'b00, 16'h0005, 16'h0003);
    get_rsp(d, o);
    check("t1_data", d, 16'h0008);
    check("t1_ovf",  o, 1'b0);
    send(2'b11, 16'hBEEF, 16'h0002);
    get_rsp(d, o);
    check("t2_data", d, 16'h0006);
    repeat (10) @(negedge clk);
    check("t2_z_hold", bus.Z, 16'h0006);

    // signed overflow, then Z + 0 clears RspOvf
    send(2'b00, 16'h7FFF, 16'h0001);
    get_rsp(d, o);
    check("t3_data",      d, 16'h8000);
    check("t3_ovf",       o, 1'b1);
    check("t3_ovf_count", bus.OvfCount, 8'd1);
    send(2'b10, 16'h1234, 16'h0000);
    get_rsp(d, o);
    check("t3_hold_data", d, 16'h8000);
    check("t3_hold_ovf",  o, 1'b0);

    // back-pressure on the response with a queued command
    bus.RspReady = 1'b0;
    send(2'b00, 16'h0001, 16'h0002);
    fork
      send(2'b01, 16'h000A, 16'h0004);
      begin
        repeat (8) @(negedge clk);
        check("t4_rsp_valid", bus.RspValid, 1'b1);
        check("t4_rsp_data",  bus.RspData,  16'h0003);
        check("t4_cmd_ready", bus.CmdReady, 1'b0);
        bus.RspReady = 1'b1;
      end
    join
    check("t4_accept_gap", 32'((dut_acc_t - dut_hs_t) / 10), 1);
    get_rsp(d, o);
    check("t4_first",  d, 16'h0003);
    get_rsp(d, o);
    check("t4_second", d, 16'h0006);

    // reset during WAIT discards the op
    send(2'b00, 16'h0064, 16'h00C8);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rsp_valid", bus.RspValid, 1'b0);
    check("t5_busy",      bus.Busy,     1'b0);
    check("t5_sel",       bus.Sel,      1'b1);
    check("t5_b",         bus.B,        '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_cmd_ready", bus.CmdReady, 1'b1);
    repeat (6) @(negedge clk);
    check("t5_no_rsp", rsp_q.size(), 0);

    // saturating counter on the CW=2 instance
    for (int k = 0; k < 5; k++) begin
      send(2'b00, 16'h7FFF, 16'h0001);
      get_rsp(d, o);
      check("t6_ovf_count2", bus2.OvfCount, exp6[k]);
      check("t6_ovf_count",  bus.OvfCount,  k + 1);
    end

    // random traffic with random response back-pressure
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(negedge clk);
          bus.RspReady = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(2'($urandom_range(0, 3)), N'($urandom), N'($urandom));
        end
        repeat (30) @(negedge clk);
        rnd_on = 1'b0;
      end
    join
    bus.RspReady = 1'b1;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
